// File: rtl/accum_buffer_ctrl.sv
// Two-bank accumulation buffer sequencer: lane-wise read-modify-write
// over several passes, then bank swap and valid/ready drain of the tile.
module accum_buffer_ctrl #(
    parameter int LANES           = 4,
    parameter int LANE_WIDTH      = 16,
    parameter int DATA_WIDTH      = LANES * LANE_WIDTH,
    parameter int BANK_ADDR_WIDTH = 7,
    parameter int BANK_DEPTH      = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BANK_ADDR_WIDTH:0]   cfg_words,
    input  logic [7:0]                 cfg_passes,
    output logic                       busy,
    output logic                       tile_done,
    input  logic                       psum_valid,
    output logic                       psum_ready,
    input  logic [DATA_WIDTH-1:0]      psum_data,
    output logic                       ren,
    output logic [BANK_ADDR_WIDTH-1:0] radr,
    input  logic [DATA_WIDTH-1:0]      rdata,
    output logic                       wen,
    output logic [BANK_ADDR_WIDTH-1:0] wadr,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic                       ren_wb,
    output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
    input  logic [DATA_WIDTH-1:0]      rdata_wb,
    output logic                       switch_banks,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last
);
    localparam int AW = BANK_ADDR_WIDTH;
    localparam int CW = BANK_ADDR_WIDTH + 1;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {A_IDLE, A_RUN, A_WAIT_SW} a_state_t;
    typedef enum logic {D_IDLE, D_RUN} d_state_t;

    a_state_t a_state, a_next;
    d_state_t d_state, d_next;

    logic [CW-1:0] words_q;
    logic [7:0]    passes_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    pass_q;

    logic          v_r, add_r, fwd_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] psum_r, wdata_q, src, sum;

    logic accept, last_addr, last_pass, start_ok;

    assign accept    = psum_valid && psum_ready;
    assign last_addr = ({1'b0, addr_q} == words_q - CW'(1));
    assign last_pass = (pass_q == passes_q - 8'd1);
    assign start_ok  = (a_state == A_IDLE) && start &&
                       (cfg_words != '0) &&
                       (cfg_words <= CW'(BANK_DEPTH));

    assign busy = (a_state != A_IDLE);
    assign ren  = accept && (pass_q != 8'd0);
    assign radr = addr_q;
    assign wen  = v_r;
    assign wadr = addr_r;

    always_comb begin
        a_next       = a_state;
        psum_ready   = 1'b0;
        switch_banks = 1'b0;
        tile_done    = 1'b0;
        unique case (a_state)
            A_IDLE: if (start_ok) a_next = A_RUN;
            A_RUN: begin
                psum_ready = 1'b1;
                if (accept && last_addr && last_pass)
                    a_next = A_WAIT_SW;
            end
            A_WAIT_SW: begin
                // Hold the swap until the final write has landed
                if (d_state == D_IDLE && !v_r) begin
                    switch_banks = 1'b1;
                    tile_done    = 1'b1;
                    a_next       = A_IDLE;
                end
            end
            default: a_next = A_IDLE;
        endcase
    end

    // Same-address read behind a pending write takes the written word
    always_comb begin
        src = fwd_r ? wdata_q : rdata;
        sum = '0;
        for (int l = 0; l < LANES; l++)
            sum[l*LANE_WIDTH +: LANE_WIDTH] =
                src[l*LANE_WIDTH +: LANE_WIDTH] +
                psum_r[l*LANE_WIDTH +: LANE_WIDTH];
        wdata = add_r ? sum : psum_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_state  <= A_IDLE;
            words_q  <= '0;
            passes_q <= '0;
            addr_q   <= '0;
            pass_q   <= '0;
            v_r      <= 1'b0;
            add_r    <= 1'b0;
            fwd_r    <= 1'b0;
            addr_r   <= '0;
            psum_r   <= '0;
            wdata_q  <= '0;
        end else begin
            a_state <= a_next;
            v_r     <= accept;
            wdata_q <= wdata;
            fwd_r   <= ren && v_r && (addr_r == addr_q);
            if (start_ok) begin
                words_q  <= cfg_words;
                passes_q <= (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
                addr_q   <= '0;
                pass_q   <= '0;
            end
            if (accept) begin
                psum_r <= psum_data;
                addr_r <= addr_q;
                add_r  <= (pass_q != 8'd0);
                if (last_addr) begin
                    addr_q <= '0;
                    pass_q <= pass_q + 8'd1;
                end else begin
                    addr_q <= addr_q + AW'(1);
                end
            end
        end
    end

    logic [CW-1:0] dwords_q, rcnt;
    logic          infl_q, infl_last_q;
    logic [DW-1:0] fifo_data [2];
    logic [1:0]    fifo_last;
    logic          wp, rp, pop, push;
    logic [1:0]    cnt, occ;

    assign push      = infl_q;
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_data[rp];
    assign out_last  = out_valid && fifo_last[rp];
    assign occ       = cnt + 2'(infl_q) - 2'(pop);
    assign ren_wb    = (d_state == D_RUN) && (rcnt < dwords_q) &&
                       (occ < 2'd2);
    assign radr_wb   = rcnt[AW-1:0];

    always_comb begin
        d_next = d_state;
        unique case (d_state)
            D_IDLE: if (switch_banks) d_next = D_RUN;
            D_RUN:  if (pop && fifo_last[rp]) d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_state      <= D_IDLE;
            dwords_q     <= '0;
            rcnt         <= '0;
            infl_q       <= 1'b0;
            infl_last_q  <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            wp           <= 1'b0;
            rp           <= 1'b0;
            cnt          <= '0;
        end else begin
            d_state     <= d_next;
            infl_q      <= ren_wb;
            infl_last_q <= ren_wb && (rcnt == dwords_q - CW'(1));
            if (switch_banks) begin
                dwords_q <= words_q;
                rcnt     <= '0;
            end else if (ren_wb) begin
                rcnt <= rcnt + CW'(1);
            end
            if (push) begin
                fifo_data[wp] <= rdata_wb;
                fifo_last[wp] <= infl_last_q;
                wp            <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_accum_buffer_ctrl.sv
// Randomized bench for accum_buffer_ctrl with a two-bank buffer model
// and a per-tile lane-sum reference queue.
module tb_accum_buffer_ctrl;
    localparam int DW = 64;
    localparam int AW = 7;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst, start, psum_valid, out_ready;
    logic [7:0] cfg_words, cfg_passes;
    logic [DW-1:0] psum_data;
    logic busy, tile_done, psum_ready, ren, wen, ren_wb;
    logic switch_banks, out_valid, out_last;
    logic [AW-1:0] radr, wadr, radr_wb;
    logic [DW-1:0] rdata, wdata, rdata_wb, out_data;

    always #5 clk = ~clk;

    accum_buffer_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_words(cfg_words), .cfg_passes(cfg_passes),
        .busy(busy), .tile_done(tile_done),
        .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_data(psum_data),
        .ren(ren), .radr(radr), .rdata(rdata),
        .wen(wen), .wadr(wadr), .wdata(wdata),
        .ren_wb(ren_wb), .radr_wb(radr_wb), .rdata_wb(rdata_wb),
        .switch_banks(switch_banks),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    // Buffer model: 1-cycle read, read-during-write returns old data
    logic [DW-1:0] bank [2][128];
    logic acc_sel = 1'b0;
    always @(posedge clk) begin
        if (ren) rdata <= bank[acc_sel][radr];
        if (ren_wb) rdata_wb <= bank[!acc_sel][radr_wb];
        if (wen) bank[acc_sel][wadr] <= wdata;
        if (switch_banks) acc_sel <= !acc_sel;
    end

    int passed = 0;
    int total = 0;
    int ren_cnt = 0;
    int sw_cnt = 0;
    int pops = 0;
    int rdy_mode = 0;
    logic [DW-1:0] last_word;
    logic [DW-1:0] exp_q[$];
    bit explast_q[$];
    logic [DW-1:0] model [128];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] r;
        int unsigned s;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            s = int'(a[l*LW +: LW]) + int'(b[l*LW +: LW]);
            r[l*LW +: LW] = 16'(s % 32'd65536);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] gen_word(input int mode,
                                               input int p, input int i);
        case (mode)
            1: return 64'h0001_0002_0003_0004 + 64'(i);
            2: return 64'h0005_0005_0005_0005;
            3: return (p == 0) ? 64'h0000_0000_0000_FFFF : 64'h1;
            4: return 64'h0007_0007_0007_0007;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Output stream monitor against the expectation queue
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic prev_last;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (ren) ren_cnt++;
            if (switch_banks) begin
                sw_cnt++;
                chk("sw_wen", {63'd0, wen}, 64'd0);
                chk("sw_tdone", {63'd0, tile_done}, 64'd1);
                chk("sw_oval", {63'd0, out_valid}, 64'd0);
            end
            if (prev_stall) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", {63'd0, out_last}, {63'd0, prev_last});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", out_data, 64'hDEAD);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                    chk("out_last", {63'd0, out_last},
                        {63'd0, explast_q.pop_front()});
                    pops++;
                    last_word = out_data;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end
    end

    int ph = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: out_ready = 1'($urandom_range(1));
            endcase
            ph++;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy || out_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("drain_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [DW-1:0] d, input bit gaps);
        bit acc = 1'b0;
        int n = 0;
        if (gaps) begin
            while ($urandom_range(3) == 0) begin
                psum_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        psum_valid = 1'b1;
        psum_data = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = psum_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("psum_timeout", 64'd0, 64'd1);
        psum_valid = 1'b0;
    endtask

    task automatic pulse_start(input int w, input int p);
        start = 1'b1;
        cfg_words = 8'(w);
        cfg_passes = 8'(p);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_tile(input int w, input int p, input int mode,
                             input bit gaps);
        int np;
        logic [DW-1:0] d;
        np = (p == 0) ? 1 : p;
        wait_idle();
        pulse_start(w, p);
        for (int k = 0; k < np; k++) begin
            for (int i = 0; i < w; i++) begin
                d = gen_word(mode, k, i);
                model[i] = (k == 0) ? d : lane_add(model[i], d);
                drive_word(d, gaps);
            end
        end
        for (int i = 0; i < w; i++) begin
            exp_q.push_back(model[i]);
            explast_q.push_back(i == w - 1);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_psum_ready"}, {63'd0, psum_ready}, 64'd0);
        chk({tag, "_ren"}, {63'd0, ren}, 64'd0);
        chk({tag, "_wen"}, {63'd0, wen}, 64'd0);
        chk({tag, "_ren_wb"}, {63'd0, ren_wb}, 64'd0);
        chk({tag, "_switch"}, {63'd0, switch_banks}, 64'd0);
        chk({tag, "_tile_done"}, {63'd0, tile_done}, 64'd0);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_out_last"}, {63'd0, out_last}, 64'd0);
        chk({tag, "_radr"}, {57'd0, radr}, 64'd0);
        chk({tag, "_wadr"}, {57'd0, wadr}, 64'd0);
        chk({tag, "_radr_wb"}, {57'd0, radr_wb}, 64'd0);
        chk({tag, "_wdata"}, wdata, 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
    endtask

    int sw0;
    initial begin
        rst = 1'b1;
        start = 1'b0;
        psum_valid = 1'b0;
        psum_data = '0;
        cfg_words = '0;
        cfg_passes = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        rdy_mode = 0;
        ren_cnt = 0;
        sw_cnt = 0;
        pops = 0;
        send_tile(4, 1, 1, 1'b0);
        chk("single_ren", 64'(ren_cnt), 64'd0);
        wait_drain();
        chk("single_sw", 64'(sw_cnt), 64'd1);
        chk("single_pops", 64'(pops), 64'd4);
        chk("single_last", last_word, 64'h0001_0002_0003_0007);

        send_tile(3, 3, 2, 1'b1);
        wait_drain();
        chk("multi_lane", last_word, 64'h000F_000F_000F_000F);

        send_tile(3, 3, 3, 1'b0);
        wait_drain();
        chk("wrap_lane", last_word, 64'h0000_0000_0000_0001);

        send_tile(1, 4, 4, 1'b0);
        wait_drain();
        chk("fwd_lane", last_word, 64'h001C_001C_001C_001C);

        rdy_mode = 1;
        sw_cnt = 0;
        pops = 0;
        send_tile(8, 1, 0, 1'b0);
        send_tile(2, 2, 0, 1'b0);
        @(negedge clk);
        chk("ovl_busy", {63'd0, busy}, 64'd1);
        chk("ovl_no_ready", {63'd0, psum_ready}, 64'd0);
        chk("ovl_sw_once", 64'(sw_cnt), 64'd1);
        wait_drain();
        chk("ovl_sw", 64'(sw_cnt), 64'd2);
        chk("ovl_pops", 64'(pops), 64'd10);

        rdy_mode = 0;
        wait_idle();
        pulse_start(4, 3);
        for (int i = 0; i < 6; i++) drive_word({$urandom, $urandom}, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrst");
        rst = 1'b0;
        pops = 0;
        send_tile(2, 1, 0, 1'b0);
        wait_drain();
        chk("midrst_pops", 64'(pops), 64'd2);

        pulse_start(0, 1);
        repeat (3) begin
            @(negedge clk);
            chk("zero_busy", {63'd0, busy}, 64'd0);
            chk("zero_ready", {63'd0, psum_ready}, 64'd0);
        end

        pops = 0;
        sw0 = sw_cnt;
        send_tile(128, 0, 0, 1'b0);
        wait_drain();
        chk("w128_pops", 64'(pops), 64'd128);
        chk("w128_sw", 64'(sw_cnt - sw0), 64'd1);

        rdy_mode = 2;
        for (int t = 0; t < 8; t++)
            send_tile($urandom_range(12, 1), $urandom_range(4), 0, 1'b1);
        send_tile(1, 3, 0, 1'b0);
        wait_drain();
        chk("rand_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/accum_buffer_ctrl.md
Name: accum_buffer_ctrl

Overview:
- Sequences the two-bank accumulation buffer (one accumulate bank, one writeback bank; 1-cycle read latency; `switch_banks` swaps roles at the clock edge).
- Accumulate side: accepts partial-sum words from the systolic array and performs read-modify-write, lane-wise, over a configured number of passes.
- When a tile is complete, swaps banks and drains the finished tile through a valid/ready output stream.
- Accumulation of the next tile overlaps the drain of the previous one.

Parameters:
- LANES, 4, number of packed accumulator lanes per word.
- LANE_WIDTH, 16, bits per lane.
- DATA_WIDTH, LANES*LANE_WIDTH, buffer word width.
- BANK_ADDR_WIDTH, 7, buffer address width.
- BANK_DEPTH, 128, words per bank.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; latch cfg and begin a tile (honoured only in A_IDLE).
- cfg_words  in  BANK_ADDR_WIDTH+1  words per tile, 1..BANK_DEPTH.
- cfg_passes  in  8  accumulation passes per tile.
- busy  out  1  accumulate FSM not in A_IDLE.
- tile_done  out  1  one-cycle pulse when the tile is handed to drain.
- psum_valid  in  1  partial-sum word valid.
- psum_ready  out  1  controller accepts psum.
- psum_data  in  DATA_WIDTH  partial-sum word.
- ren, radr, rdata  out/out/in  1/BANK_ADDR_WIDTH/DATA_WIDTH  accumulate-bank read port.
- wen, wadr, wdata  out/out/out  1/BANK_ADDR_WIDTH/DATA_WIDTH  accumulate-bank write port.
- ren_wb, radr_wb, rdata_wb  out/out/in  1/BANK_ADDR_WIDTH/DATA_WIDTH  writeback-bank read port.
- switch_banks  out  1  one-cycle bank swap pulse.
- out_valid  out  1  drained word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  drained word.
- out_last  out  1  marks final word of tile.

Behaviour:
- Reset:
  - Both FSMs idle; all counters 0; output FIFO empty.
  - All outputs 0: psum_ready, ren, wen, ren_wb, switch_banks, out_valid, out_last, busy, tile_done; all address and data outputs 0.
  - Reset mid-operation abandons the tile and the drain immediately; the next start begins clean.
- Start:
  - cfg_words=0 → start ignored.
  - cfg_passes=0 → treated as 1.
- Accumulate FSM A_IDLE→A_RUN→A_WAIT_SW→A_IDLE:
  - psum_ready=1 only in A_RUN.
  - Input order is addr 0..cfg_words-1, repeated once per pass.
  - Address and pass counters are internal; address wraps to 0 and pass increments after word cfg_words-1.
- Pass 0:
  - Accept in cycle t → wen=1 in cycle t+1 with wadr=addr and wdata=psum.
  - No read is issued.
- Pass ≥1:
  - Accept in cycle t → ren=1, radr=addr in cycle t; psum and addr are registered.
  - Cycle t+1: wen=1, wdata = lane-wise (rdata + psum_r) mod 2^LANE_WIDTH. No carry crosses lanes.
- Throughput: 1 word/cycle sustained.
- Forwarding:
  - Applies when the read address in cycle t equals the write address pending in cycle t (cfg_words=1, back-to-back).
  - The t+1 add uses the t-cycle wdata instead of rdata.
  - Buffer read-during-write is undefined, so forwarding is mandatory.
- After the write of the final word of the final pass, go to A_WAIT_SW.
- A_WAIT_SW:
  - Stays until the drain FSM is in D_IDLE.
  - Then, for one cycle: switch_banks=1 and tile_done=1; the drain launches with the latched cfg_words; the FSM returns to A_IDLE.
  - switch_banks is never asserted while wen is high.
- Drain FSM D_IDLE→D_RUN→D_IDLE:
  - Read counter 0..words-1 on radr_wb.
  - First ren_wb is no earlier than the cycle after switch_banks.
  - 2-entry output FIFO. Issue ren_wb only if FIFO occupancy + reads in flight < 2, accounting for the same-cycle pop.
  - rdata_wb is pushed one cycle after ren_wb.
  - out_valid = FIFO non-empty; pop on out_valid&&out_ready.
  - out_data and out_last are stable while out_valid&&!out_ready.
  - out_last=1 on word words-1.
  - Return to D_IDLE when the last word is popped.
  - Full throughput with out_ready held high: 1 word/cycle after 1-cycle fill latency.
- Overlap: start is accepted in A_IDLE while the drain is running; the new tile accumulates in the new accumulate bank.

Test Plan:
- Single-pass tile: cfg_words=4, passes=1, psum 0x0001_0002_0003_0004+i.
  - → exactly one switch_banks pulse.
  - → out_data sequence equals inputs, out_last on word 3.
  - → no ren during the tile.
- Multi-pass tile: words=3, passes=3, every lane=0x0005 each pass.
  - → every output lane 0x000F.
  - Repeat with lane inputs 0xFFFF, 0x0001, 0x0001 → lane result 0x0001, neighbouring lanes unaffected.
- Forwarding: words=1, passes=4, psum lanes=0x0007 on consecutive cycles → single output lanes 0x001C.
- Backpressure: words=8, out_ready pattern 1,0,0,1 repeating.
  - → all 8 words delivered in order, no duplicates or drops, data stable while stalled.
  - A second tile is started mid-drain: it accumulates, waits in A_WAIT_SW until the drain's last pop, then switch_banks pulses.
- Reset mid-tile: rst in pass 1 of words=4 → next cycle all outputs 0, busy=0.
  - A fresh start, words=2, passes=1 → outputs correct, tile not mixed with old data.
- Config corners:
  - cfg_words=0 start → busy stays 0.
  - cfg_words=128, passes=0 → behaves as one pass; out_last on word 127; 128 words drained.
